motor_fsm_ctrl: RTL and testbench

Single-door motor controller (`motor_fsm`) that drives a bidirectional motor (up/down) from a push-button `activate` input and two end-of-travel limit switches. It sits between debounced front-panel/limit-switch inputs and the motor driver stage. Outputs are registered and never both asserted. An optional travel watchdog stops the motor if a limit is not reached in time.

---
 rtl/motor_fsm_pkg.sv | 19 +
 rtl/motor_travel_timer.sv | 28 ++
 rtl/motor_fsm_ctrl.sv | 99 +++++++++
 tb/tb_motor_fsm_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/motor_fsm_pkg.sv
// rtl/motor_fsm_pkg.sv - state and direction definitions for the door motor controller
package motor_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_DN,
    MOVE_UP,
    STOPPED,
    FAULT
  } motor_state_t;

  localparam logic DIR_DN = 1'b0;
  localparam logic DIR_UP = 1'b1;

  function automatic logic is_moving(input motor_state_t s);
    return (s == MOVE_DN) || (s == MOVE_UP);
  endfunction

endpackage

// File: rtl/motor_travel_timer.sv
// rtl/motor_travel_timer.sv - travel watchdog counter, used only when MOTOR_TIMEOUT_EN is defined
module motor_travel_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/motor_fsm_ctrl.sv
// rtl/motor_fsm_ctrl.sv - single-door up/down motor FSM; MOTOR_TIMEOUT_EN adds a travel watchdog
module motor_fsm_ctrl
  import motor_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic activate,
  input  logic up_limit,
  input  logic dn_limit,
  output logic motor_up,
  output logic motor_dn
);

  motor_state_t state_q, state_d;
  logic         last_dir_q, last_dir_d;
  logic         act_q;
  logic         cmd;
  logic         expired;

  assign cmd = activate & ~act_q;

`ifdef MOTOR_TIMEOUT_EN
  // Counter is held clear outside motion, so it starts from zero on every entry.
  motor_travel_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!is_moving(state_q)),
    .enable (is_moving(state_q)),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dir_q <= DIR_DN;
      act_q      <= 1'b0;
      motor_up   <= 1'b0;
      motor_dn   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      act_q      <= activate;
      motor_up   <= (state_d == MOVE_UP);
      motor_dn   <= (state_d == MOVE_DN);
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    if (up_limit && dn_limit) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd) state_d = dn_limit ? MOVE_UP : MOVE_DN;
        end
        // Limit is checked first so it beats a same-cycle command or watchdog stop.
        MOVE_DN: begin
          if (dn_limit) begin
            state_d    = IDLE;
            last_dir_d = DIR_DN;
          end else if (cmd || expired) begin
            state_d    = STOPPED;
            last_dir_d = DIR_DN;
          end
        end
        MOVE_UP: begin
          if (up_limit) begin
            state_d    = IDLE;
            last_dir_d = DIR_UP;
          end else if (cmd || expired) begin
            state_d    = STOPPED;
            last_dir_d = DIR_UP;
          end
        end
        STOPPED: begin
          if (cmd) begin
            if (dn_limit)      state_d = MOVE_UP;
            else if (up_limit) state_d = MOVE_DN;
            else               state_d = (last_dir_q == DIR_UP) ? MOVE_DN : MOVE_UP;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_fsm_ctrl.sv
// tb/tb_motor_fsm_ctrl.sv - self-checking bench for motor_fsm_ctrl; watchdog checks follow MOTOR_TIMEOUT_EN
module tb_motor_fsm_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic activate;
  logic up_limit;
  logic dn_limit;
  logic motor_up;
  logic motor_dn;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic  act;
    logic  up;
    logic  dn;
    logic  exp_up;
    logic  exp_dn;
    string name;
  } vec_t;

  vec_t vecs[$];

  motor_fsm_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .activate(activate),
    .up_limit(up_limit),
    .dn_limit(dn_limit),
    .motor_up(motor_up),
    .motor_dn(motor_dn)
  );

  always #5 clk = ~clk;

  task automatic add(input logic a, input logic u, input logic d,
                     input logic eu, input logic ed, input string n);
    vec_t v;
    v.act = a; v.up = u; v.dn = d; v.exp_up = eu; v.exp_dn = ed; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic eu, input logic ed);
    checks++;
    if (motor_up !== eu || motor_dn !== ed || (motor_up & motor_dn)) begin
      errors++;
      $display("FAIL %s: got up=%b dn=%b, expected up=%b dn=%b", n, motor_up, motor_dn, eu, ed);
    end
  endtask

  task automatic step(input logic a, input logic u, input logic d);
    @(negedge clk);
    activate = a; up_limit = u; dn_limit = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; activate = 1'b0; up_limit = 1'b0; dn_limit = 1'b0;

    //   act up dn  eu ed
    add(0, 1, 0, 0, 0, "idle_at_top");
    add(1, 1, 0, 0, 1, "cmd_at_top_moves_dn");
    add(0, 0, 0, 0, 1, "dn_travel_0");
    add(0, 0, 0, 0, 1, "dn_travel_1");
    add(0, 0, 0, 0, 1, "dn_travel_2");
    add(0, 0, 0, 0, 1, "dn_travel_3");
    add(0, 0, 1, 0, 0, "dn_limit_stops");
    add(1, 0, 1, 1, 0, "cmd_at_bottom_moves_up");
    add(1, 0, 1, 1, 0, "held_act_no_recmd_0");
    add(1, 0, 0, 1, 0, "held_act_no_recmd_1");
    add(0, 0, 0, 1, 0, "up_travel_0");
    add(0, 0, 0, 1, 0, "up_travel_1");
    add(0, 0, 0, 1, 0, "up_travel_2");
    add(0, 1, 0, 0, 0, "up_limit_stops");
    add(1, 1, 0, 0, 1, "start_dn");
    add(0, 0, 0, 0, 1, "dn_running");
    add(1, 0, 0, 0, 0, "cmd_stops_dn");
    add(0, 0, 0, 0, 0, "stopped_holds");
    add(1, 0, 0, 1, 0, "resume_opposite_up");
    add(0, 0, 0, 1, 0, "up_running");
    add(1, 0, 0, 0, 0, "cmd_stops_up");
    add(0, 0, 0, 0, 0, "stopped_holds_2");
    add(1, 0, 0, 0, 1, "resume_opposite_dn");
    add(0, 0, 0, 0, 1, "dn_running_2");
    add(1, 0, 1, 0, 0, "limit_beats_cmd");
    add(0, 0, 0, 0, 0, "idle_after_tie");
    add(1, 0, 0, 0, 1, "idle_not_stopped");
    add(0, 0, 0, 0, 1, "dn_running_3");
    add(1, 0, 0, 0, 0, "cmd_stops_dn_2");
    add(0, 1, 0, 0, 0, "stopped_limit_no_cmd");
    add(1, 1, 0, 0, 1, "stopped_up_limit_override");
    add(0, 0, 1, 0, 0, "dn_limit_stops_2");
    add(0, 1, 1, 0, 0, "both_limits_fault");
    add(1, 0, 0, 0, 0, "fault_ignores_cmd_0");
    add(0, 0, 0, 0, 0, "fault_hold");
    add(1, 1, 0, 0, 0, "fault_ignores_cmd_1");
    add(0, 0, 1, 0, 0, "fault_hold_2");
    add(1, 0, 1, 0, 0, "fault_ignores_cmd_2");

    #2;
    check("reset_outputs", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].act, vecs[i].up, vecs[i].dn);
      check(vecs[i].name, vecs[i].exp_up, vecs[i].exp_dn);
    end

    // Reset leaves FAULT; activate held through release is one command.
    @(negedge clk);
    rst_n = 1'b0; activate = 1'b1; up_limit = 1'b1; dn_limit = 1'b0;
    #1;
    check("reset_from_fault", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("act_high_through_reset", 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("moving_before_async_rst", 1'b0, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_motion", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_release", 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("cmd_after_reset_dn", 1'b0, 1'b1);

`ifdef MOTOR_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("watchdog_running_%0d", k), 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0);
    check("watchdog_stop", 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("resume_after_watchdog", 1'b1, 1'b0);
`else
    for (int k = 1; k < 40; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("no_watchdog_running_%0d", k), 1'b0, 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
